uc_mc: RTL and testbench
========================

Name: uc_mc

Overview:
Multi-cycle, parametrised control unit for the 16-bit accumulator/stack CPU. It replaces the purely combinational decoder with an FSM that sequences fetch and execute. The FSM stalls on I/O port handshakes, supports call/return through the hardware stack, and services vectored interrupts at instruction boundaries. It sits between the program memory and the datapath (PC mux, register bank, ALU, stack, data memory, output port registers).

Parameters:
OPW, 16, instruction width; opcode class in [OPW-1:OPW-6].
NPORTS, 4, number of input and output ports (power of 2, 2..8).
NIRQ, 4, interrupt request lines (1..8).
VECW, 10, width of the jump/vector address.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
opcode  in  OPW  instruction word from program memory.
z  in  1  zero flag from the datapath.
irq  in  NIRQ  level-sensitive interrupt requests.
port_rdy  in  NPORTS  input port has data.
port_ack  in  NPORTS  output port accepted data.
ir_we  out  1  latch instruction register.
pc_en  out  1  PC update enable.
s_inc  out  1  1 = PC+1, 0 = jump target.
s_pcsrc  out  2  PC target: 00 immediate, 01 stack top, 10 irq vector.
we3, wez, we4, push, pop, s_pila, s_out  out  1 each  datapath strobes (same meaning as the current decoder).
we_out  out  NPORTS  one-hot output port write.
s_port  out  clog2(NPORTS)  input port select.
s_inm  out  2  register-bank write source.
op_alu  out  3  ALU operation.
irq_vec  out  VECW  vector = {index, 2'b00} zero-extended.
ie  out  1  interrupt enable flag.
busy  out  1  high outside FETCH.

Behaviour:
- Reset (async, reset_n=0): state=FETCH, ie=0, all outputs 0 except s_inc=1.
- States: FETCH, EXEC, WAIT_IN, WAIT_OUT, IRQ.
- Strobes are asserted only in the single commit cycle; they are 0 in every other cycle.
- FETCH:
  - If ie and |irq: go to IRQ. Priority is lowest index.
  - Else: ir_we=1, go to EXEC.
- EXEC, decode of opcode[OPW-1:OPW-6]:
  - 0xxxxx ALU: op_alu=opcode[OPW-2:OPW-4], we3=wez=1.
  - 100000 load immediate: s_inm=01, we3=1.
  - 100001 jump: s_inc=0.
  - 100010 jump if z: s_inc=~z.
  - 100011 jump if not z: s_inc=z.
  - 100100 push: push=1.
  - 100101 pop: pop=1, s_pila=1.
  - 111000 load from memory: s_inm=10, we3=1.
  - 1111xx store to memory: we4=1.
  - In all of the above: pc_en=1, then go to FETCH.
  - 100110 input: s_port=opcode[clog2(NPORTS)+3:4], go to WAIT_IN.
  - 100111 and 101000 output: go to WAIT_OUT. Port index is opcode[clog2(NPORTS)-1:0]; s_out=1 for 101000.
  - 101001 call: push=1, s_inc=0, pc_en=1 (PC+1 goes to the stack), then FETCH.
  - 101010 ret: pop=1, s_inc=0, s_pcsrc=01, pc_en=1, then FETCH.
  - 101011 reti: same as ret, and ie←1.
  - 101100 ei: ie←1, pc_en=1.
  - 101101 di: ie←0, pc_en=1.
  - Undefined opcode: NOP (pc_en=1 only).
- WAIT_IN: hold s_port. When port_rdy[s_port]=1: s_inm=11, we3=1, pc_en=1, go to FETCH. Otherwise stall indefinitely.
- WAIT_OUT: hold s_out. Assert we_out[idx] every cycle until port_ack[idx]=1. In the ack cycle pc_en=1, then go to FETCH.
- IRQ, one cycle: push=1 (saves the current PC, not PC+1), s_inc=0, s_pcsrc=10, pc_en=1, ie←0, then FETCH.
- An irq arriving during EXEC/WAIT is sampled only at the next FETCH. irq dropping before FETCH is not serviced.
- An ei followed immediately by pending irq: the interrupt is taken at the very next FETCH.
- reset_n deassertion is synchronous-released externally; reset mid-WAIT aborts without any strobe.

Decomposition:
- Package uc_pkg holds:
  - Opcode-class localparams: OP_ALU, OP_LDI, OP_J, OP_JZ, OP_JNZ, OP_PUSH, OP_POP, OP_IN, OP_OUT, OP_OUTI, OP_CALL, OP_RET, OP_RETI, OP_EI, OP_DI, OP_LW, OP_SW.
  - State encoding.
  - s_inm and s_pcsrc codes.
- Sub-module irq_prio: combinational NIRQ-input priority encoder (valid, index).

Test Plan:
- Reset, then ALU opcode 0x3000 → FETCH(ir_we=1), EXEC op_alu=011, we3=wez=pc_en=1; total 2 cycles.
- JZ with z=0 then z=1 → s_inc=1 then s_inc=0, pc_en=1 each.
- IN port 2, port_rdy=0 for 5 cycles then 1 → no we3 for 5 cycles; 6th cycle we3=1, s_inm=11, s_port=2.
- OUT port 3, ack after 3 cycles → we_out=4'b1000 held 4 cycles, pc_en only in ack cycle.
- ei, then irq=4'b0110 → IRQ state, irq_vec=0x004, push=1, ie=0; reti restores ie=1, pop=1, s_pcsrc=01.
- reset_n pulsed low mid-WAIT_OUT → we_out=0 immediately (async), state FETCH, ie=0.

Source files
------------

// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcode
// classes (instruction bits [OPW-1:OPW-6]) and datapath mux select codes.
package uc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_EXEC     = 3'd1,
        ST_WAIT_IN  = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_IRQ      = 3'd4
    } state_t;

    // OP_ALU covers 0xxxxx and OP_SW covers 1111xx; see the class helpers below.
    localparam logic [5:0] OP_ALU  = 6'b000000;
    localparam logic [5:0] OP_LDI  = 6'b100000;
    localparam logic [5:0] OP_J    = 6'b100001;
    localparam logic [5:0] OP_JZ   = 6'b100010;
    localparam logic [5:0] OP_JNZ  = 6'b100011;
    localparam logic [5:0] OP_PUSH = 6'b100100;
    localparam logic [5:0] OP_POP  = 6'b100101;
    localparam logic [5:0] OP_IN   = 6'b100110;
    localparam logic [5:0] OP_OUT  = 6'b100111;
    localparam logic [5:0] OP_OUTI = 6'b101000;
    localparam logic [5:0] OP_CALL = 6'b101001;
    localparam logic [5:0] OP_RET  = 6'b101010;
    localparam logic [5:0] OP_RETI = 6'b101011;
    localparam logic [5:0] OP_EI   = 6'b101100;
    localparam logic [5:0] OP_DI   = 6'b101101;
    localparam logic [5:0] OP_LW   = 6'b111000;
    localparam logic [5:0] OP_SW   = 6'b111100;

    localparam logic [1:0] INM_ALU  = 2'b00;
    localparam logic [1:0] INM_IMM  = 2'b01;
    localparam logic [1:0] INM_MEM  = 2'b10;
    localparam logic [1:0] INM_PORT = 2'b11;

    localparam logic [1:0] PCSRC_IMM = 2'b00;
    localparam logic [1:0] PCSRC_STK = 2'b01;
    localparam logic [1:0] PCSRC_VEC = 2'b10;

    function automatic logic is_alu(input logic [5:0] cls);
        return cls[5] == OP_ALU[5];
    endfunction

    function automatic logic is_sw(input logic [5:0] cls);
        return cls[5:2] == OP_SW[5:2];
    endfunction

endpackage

// File: rtl/uc_mc_irq_prio.sv
// Combinational interrupt priority encoder: lowest active request index wins.
module irq_prio #(
    parameter int NIRQ = 4,
    parameter int IW   = (NIRQ > 1) ? $clog2(NIRQ) : 1
) (
    input  logic [NIRQ-1:0] req_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        // Scan downwards so the lowest set bit is the last (winning) write.
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/uc_mc.sv
// Multi-cycle control unit for the 16-bit accumulator/stack CPU: sequences
// fetch/execute, stalls on port handshakes and takes vectored interrupts.
module uc_mc
    import uc_pkg::*;
#(
    parameter int OPW    = 16,
    parameter int NPORTS = 4,
    parameter int NIRQ   = 4,
    parameter int VECW   = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [OPW-1:0]            opcode,
    input  logic                      z,
    input  logic [NIRQ-1:0]           irq,
    input  logic [NPORTS-1:0]         port_rdy,
    input  logic [NPORTS-1:0]         port_ack,
    output logic                      ir_we,
    output logic                      pc_en,
    output logic                      s_inc,
    output logic [1:0]                s_pcsrc,
    output logic                      we3,
    output logic                      wez,
    output logic                      we4,
    output logic                      push,
    output logic                      pop,
    output logic                      s_pila,
    output logic                      s_out,
    output logic [NPORTS-1:0]         we_out,
    output logic [$clog2(NPORTS)-1:0] s_port,
    output logic [1:0]                s_inm,
    output logic [2:0]                op_alu,
    output logic [VECW-1:0]           irq_vec,
    output logic                      ie,
    output logic                      busy
);

    localparam int PW = $clog2(NPORTS);
    localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    state_t          state_q, state_d;
    logic            ie_q, ie_d;
    logic [PW-1:0]   port_q, port_d;
    logic [PW-1:0]   oidx_q, oidx_d;
    logic            sout_q, sout_d;
    logic [VECW-1:0] vec_q, vec_d;

    logic            irq_valid;
    logic [IW-1:0]   irq_idx;
    logic [5:0]      cls;
    logic            unused_opcode;

    assign cls           = opcode[OPW-1:OPW-6];
    assign unused_opcode = ^opcode;

    irq_prio #(
        .NIRQ (NIRQ),
        .IW   (IW)
    ) u_irq_prio (
        .req_i   (irq),
        .valid_o (irq_valid),
        .idx_o   (irq_idx)
    );

    always_comb begin
        state_d = state_q;
        ie_d    = ie_q;
        port_d  = port_q;
        oidx_d  = oidx_q;
        sout_d  = sout_q;
        vec_d   = vec_q;

        ir_we   = 1'b0;
        pc_en   = 1'b0;
        s_inc   = 1'b1;
        s_pcsrc = PCSRC_IMM;
        we3     = 1'b0;
        wez     = 1'b0;
        we4     = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        s_pila  = 1'b0;
        s_out   = 1'b0;
        we_out  = '0;
        s_port  = port_q;
        s_inm   = INM_ALU;
        op_alu  = 3'b000;

        unique case (state_q)
            ST_FETCH: begin
                if (ie_q && irq_valid) begin
                    // Interrupts are masked as soon as one is accepted.
                    state_d           = ST_IRQ;
                    ie_d              = 1'b0;
                    vec_d             = '0;
                    vec_d[IW+1:2]     = irq_idx;
                end else begin
                    // Gated so the instruction latch stays quiet while reset is held.
                    ir_we   = reset_n;
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                if (is_alu(cls)) begin
                    op_alu = opcode[OPW-2:OPW-4];
                    we3    = 1'b1;
                    wez    = 1'b1;
                    pc_en  = 1'b1;
                end else if (is_sw(cls)) begin
                    we4   = 1'b1;
                    pc_en = 1'b1;
                end else begin
                    case (cls)
                        OP_LDI: begin
                            s_inm = INM_IMM;
                            we3   = 1'b1;
                            pc_en = 1'b1;
                        end
                        OP_J: begin
                            s_inc = 1'b0;
                            pc_en = 1'b1;
                        end
                        OP_JZ: begin
                            s_inc = ~z;
                            pc_en = 1'b1;
                        end
                        OP_JNZ: begin
                            s_inc = z;
                            pc_en = 1'b1;
                        end
                        OP_PUSH: begin
                            push  = 1'b1;
                            pc_en = 1'b1;
                        end
                        OP_POP: begin
                            pop    = 1'b1;
                            s_pila = 1'b1;
                            pc_en  = 1'b1;
                        end
                        OP_LW: begin
                            s_inm = INM_MEM;
                            we3   = 1'b1;
                            pc_en = 1'b1;
                        end
                        OP_IN: begin
                            port_d  = opcode[PW+3:4];
                            s_port  = opcode[PW+3:4];
                            state_d = ST_WAIT_IN;
                        end
                        OP_OUT, OP_OUTI: begin
                            oidx_d  = opcode[PW-1:0];
                            sout_d  = (cls == OP_OUTI);
                            s_out   = (cls == OP_OUTI);
                            state_d = ST_WAIT_OUT;
                        end
                        OP_CALL: begin
                            // PC+1 is on the stack input while PC loads the target.
                            push  = 1'b1;
                            s_inc = 1'b0;
                            pc_en = 1'b1;
                        end
                        OP_RET, OP_RETI: begin
                            pop     = 1'b1;
                            s_inc   = 1'b0;
                            s_pcsrc = PCSRC_STK;
                            pc_en   = 1'b1;
                            if (cls == OP_RETI) ie_d = 1'b1;
                        end
                        OP_EI: begin
                            ie_d  = 1'b1;
                            pc_en = 1'b1;
                        end
                        OP_DI: begin
                            ie_d  = 1'b0;
                            pc_en = 1'b1;
                        end
                        default: pc_en = 1'b1;
                    endcase
                end
            end

            ST_WAIT_IN: begin
                if (port_rdy[port_q]) begin
                    s_inm   = INM_PORT;
                    we3     = 1'b1;
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_WAIT_OUT: begin
                s_out          = sout_q;
                we_out[oidx_q] = 1'b1;
                if (port_ack[oidx_q]) begin
                    pc_en   = 1'b1;
                    state_d = ST_FETCH;
                end
            end

            ST_IRQ: begin
                // PC is not advanced before this, so the interrupted address is pushed.
                push    = 1'b1;
                s_inc   = 1'b0;
                s_pcsrc = PCSRC_VEC;
                pc_en   = 1'b1;
                ie_d    = 1'b0;
                state_d = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            ie_q    <= 1'b0;
            port_q  <= '0;
            oidx_q  <= '0;
            sout_q  <= 1'b0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            ie_q    <= ie_d;
            port_q  <= port_d;
            oidx_q  <= oidx_d;
            sout_q  <= sout_d;
            vec_q   <= vec_d;
        end
    end

    assign irq_vec = vec_q;
    assign ie      = ie_q;
    assign busy    = (state_q != ST_FETCH);

endmodule

// File: tb/tb_uc_mc.sv
// Directed bench for uc_mc: per-cycle expected control words are queued as
// stimulus is applied and compared against the DUT mid-cycle.
module tb_uc_mc;

    typedef struct packed {
        logic       ir_we;
        logic       pc_en;
        logic       s_inc;
        logic [1:0] s_pcsrc;
        logic       we3;
        logic       wez;
        logic       we4;
        logic       push;
        logic       pop;
        logic       s_pila;
        logic       s_out;
        logic [3:0] we_out;
        logic [1:0] s_port;
        logic [1:0] s_inm;
        logic [2:0] op_alu;
        logic [9:0] irq_vec;
        logic       ie;
        logic       busy;
    } sig_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] opcode;
    logic        z;
    logic [3:0]  irq;
    logic [3:0]  port_rdy;
    logic [3:0]  port_ack;

    logic       ir_we, pc_en, s_inc, we3, wez, we4, push, pop, s_pila, s_out, ie, busy;
    logic [1:0] s_pcsrc, s_port, s_inm;
    logic [3:0] we_out;
    logic [2:0] op_alu;
    logic [9:0] irq_vec;

    int n_cmp = 0;
    int n_bad = 0;

    sig_t  exp_q[$];
    string tag_q[$];

    logic       m_ie;
    logic [9:0] m_vec;
    logic [1:0] m_port;
    sig_t       e;

    always #5 clk = ~clk;

    uc_mc #(
        .OPW(16), .NPORTS(4), .NIRQ(4), .VECW(10)
    ) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .z(z), .irq(irq),
        .port_rdy(port_rdy), .port_ack(port_ack),
        .ir_we(ir_we), .pc_en(pc_en), .s_inc(s_inc), .s_pcsrc(s_pcsrc),
        .we3(we3), .wez(wez), .we4(we4), .push(push), .pop(pop),
        .s_pila(s_pila), .s_out(s_out), .we_out(we_out), .s_port(s_port),
        .s_inm(s_inm), .op_alu(op_alu), .irq_vec(irq_vec), .ie(ie), .busy(busy)
    );

    function automatic sig_t base(input logic bsy);
        sig_t b;
        b         = '0;
        b.s_inc   = 1'b1;
        b.s_port  = m_port;
        b.irq_vec = m_vec;
        b.ie      = m_ie;
        b.busy    = bsy;
        return b;
    endfunction

    function automatic sig_t observe();
        sig_t o;
        o.ir_we = ir_we;   o.pc_en = pc_en;   o.s_inc = s_inc;   o.s_pcsrc = s_pcsrc;
        o.we3 = we3;       o.wez = wez;       o.we4 = we4;       o.push = push;
        o.pop = pop;       o.s_pila = s_pila; o.s_out = s_out;   o.we_out = we_out;
        o.s_port = s_port; o.s_inm = s_inm;   o.op_alu = op_alu; o.irq_vec = irq_vec;
        o.ie = ie;         o.busy = busy;
        return o;
    endfunction

    task automatic check_one();
        sig_t  want, got;
        string t;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: observed=%h required=queued entry", observe());
        end else begin
            want = exp_q.pop_front();
            t    = tag_q.pop_front();
            got  = observe();
            n_cmp++;
            assert (got === want) else begin
                n_bad++;
                $error("FAIL %s: observed=%h expected=%h", t, got, want);
            end
        end
    endtask

    // One clock cycle: queue the expectation, compare at negedge, return at posedge+1.
    task automatic cyc(input string tag, input sig_t ex);
        exp_q.push_back(ex);
        tag_q.push_back(tag);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [15:0] op);
        sig_t f;
        opcode  = op;
        f       = base(1'b0);
        f.ir_we = 1'b1;
        cyc(tag, f);
    endtask

    initial begin
        reset_n = 1'b0; opcode = '0; z = 1'b0; irq = '0; port_rdy = '0; port_ack = '0;
        m_ie = 1'b0; m_vec = '0; m_port = '0;
        @(posedge clk);
        #1;
        cyc("reset_state", base(1'b0));

        reset_n = 1'b1;
        fetch("alu_fetch", 16'h3000);
        e = base(1'b1); e.op_alu = 3'b011; e.we3 = 1; e.wez = 1; e.pc_en = 1;
        cyc("alu_exec", e);

        z = 1'b0;
        fetch("jz0_fetch", 16'h8800);
        e = base(1'b1); e.pc_en = 1;
        cyc("jz0_exec", e);
        z = 1'b1;
        fetch("jz1_fetch", 16'h8800);
        e = base(1'b1); e.s_inc = 0; e.pc_en = 1;
        cyc("jz1_exec", e);

        fetch("lw_fetch", 16'hE000);
        e = base(1'b1); e.s_inm = 2'b10; e.we3 = 1; e.pc_en = 1;
        cyc("lw_exec", e);
        fetch("sw_fetch", 16'hF000);
        e = base(1'b1); e.we4 = 1; e.pc_en = 1;
        cyc("sw_exec", e);

        // Input from port 2 with the other ready bits set while stalled.
        fetch("in_fetch", 16'h9820);
        port_rdy = 4'b1011;
        e = base(1'b1); e.s_port = 2'd2;
        cyc("in_exec", e);
        m_port = 2'd2;
        for (int i = 0; i < 5; i++) cyc("in_stall", base(1'b1));
        port_rdy = 4'b0100;
        e = base(1'b1); e.s_inm = 2'b11; e.we3 = 1; e.pc_en = 1;
        cyc("in_commit", e);
        port_rdy = '0;

        // Output to port 3; acks on other ports must be ignored.
        fetch("out_fetch", 16'h9C03);
        cyc("out_exec", base(1'b1));
        port_ack = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            e = base(1'b1); e.we_out = 4'b1000;
            cyc("out_stall", e);
        end
        port_ack = 4'b1000;
        e = base(1'b1); e.we_out = 4'b1000; e.pc_en = 1;
        cyc("out_ack", e);
        port_ack = '0;

        // ei, then a pending irq is taken at the next fetch (index 1 wins).
        fetch("ei_fetch", 16'hB000);
        irq = 4'b0110;
        e = base(1'b1); e.pc_en = 1;
        cyc("ei_exec", e);
        m_ie = 1'b1;
        opcode = 16'h0000;
        cyc("irq_fetch", base(1'b0));
        m_ie = 1'b0; m_vec = 10'h004;
        e = base(1'b1); e.push = 1; e.s_inc = 0; e.s_pcsrc = 2'b10; e.pc_en = 1;
        cyc("irq_entry", e);
        fetch("reti_fetch", 16'hAC00);
        irq = '0;
        e = base(1'b1); e.pop = 1; e.s_inc = 0; e.s_pcsrc = 2'b01; e.pc_en = 1;
        cyc("reti_exec", e);
        m_ie = 1'b1;

        // Reset in the middle of an output handshake.
        fetch("outi_fetch", 16'hA001);
        port_ack = 4'b1101;
        e = base(1'b1); e.s_out = 1;
        cyc("outi_exec", e);
        e = base(1'b1); e.s_out = 1; e.we_out = 4'b0010;
        cyc("outi_stall", e);
        #2;
        reset_n = 1'b0;
        m_ie = 1'b0; m_vec = '0; m_port = '0;
        cyc("reset_mid_wait", base(1'b0));
        reset_n  = 1'b1;
        port_ack = '0;

        fetch("call_fetch", 16'hA400);
        e = base(1'b1); e.push = 1; e.s_inc = 0; e.pc_en = 1;
        cyc("call_exec", e);
        fetch("ret_fetch", 16'hA800);
        e = base(1'b1); e.pop = 1; e.s_inc = 0; e.s_pcsrc = 2'b01; e.pc_en = 1;
        cyc("ret_exec", e);
        fetch("undef_fetch", 16'hB800);
        e = base(1'b1); e.pc_en = 1;
        cyc("undef_exec", e);
        z = 1'b1;
        fetch("jnz_fetch", 16'h8C00);
        e = base(1'b1); e.pc_en = 1;
        cyc("jnz_exec", e);
        fetch("pop_fetch", 16'h9400);
        e = base(1'b1); e.pop = 1; e.s_pila = 1; e.pc_en = 1;
        cyc("pop_exec", e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
